load_queue: RTL and testbench
=============================

Name: load_queue

Overview:
- Circular load queue sitting directly upstream of the data-cache stage `ds`.
- Allocates entries at dispatch and captures memory block indices from address generation.
- Issues one query at a time to `ds`, tracks hit, miss-acknowledge and fill responses, writes loaded blocks back, and retires in order on commit.
- Flush empties the queue.

Parameters:
- SIZE, 8, number of entries; power of two, ≥2.
- IDX_W, $clog2(SIZE), queue index width.
- MEM_IDX_W, 16, memory block index width.
- BLK_W, 64, data block width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries.
- disp_valid  in  1  allocate request.
- disp_ready  out  1  high when not full.
- disp_idx  out  IDX_W  index granted (equals tail).
- addr_valid  in  1  address write.
- addr_lq_idx  in  IDX_W  target entry.
- addr_mem_idx  in  MEM_IDX_W  block index.
- ds_qry  out  1  query to `ds`.
- ds_qry_mem_idx  out  MEM_IDX_W  queried block.
- ds_qry_lq_idx  out  IDX_W  issuing entry.
- ds_hit  in  1  same-cycle hit for the current query.
- ds_hit_blk  in  BLK_W  hit data.
- ds_ack  in  1  miss accepted by memory.
- ds_ack_lq_idx  in  IDX_W  entry accepted.
- ds_ans  in  1  fill return.
- ds_ans_lq_idx  in  IDX_W  entry being filled.
- ds_ans_blk  in  BLK_W  fill data.
- wb_valid  out  1  writeback available.
- wb_lq_idx  out  IDX_W  entry written back.
- wb_blk  out  BLK_W  loaded block.
- wb_ready  in  1  writeback consumed.
- commit  in  1  retire head if it is WRITTEN.

Behaviour:
- Entry states: FREE, ALLOC, READY, ISSUED, WAIT, DONE, WRITTEN.
- Per-entry storage: state, mem_idx, blk.
- Queue pointers: head, tail, count (IDX_W+1 bits). Pointers wrap modulo SIZE.
- Reset/flush:
  - All entries FREE; head = tail = count = 0.
  - Outputs: disp_ready = 1, disp_idx = 0, ds_qry = 0, wb_valid = 0, all data/index outputs 0.
  - Flush is synchronous and has priority over every other event in that cycle.
- Dispatch:
  - disp_ready = (count != SIZE).
  - On disp_valid && disp_ready: tail entry → ALLOC, tail++, count++.
- Address write:
  - If addr_lq_idx is ALLOC: store mem_idx, state → READY.
  - Writes to any other state are ignored.
- Issue:
  - Permitted only when no entry is ISSUED.
  - Selects the oldest READY entry, scanning from head.
  - ds_qry and qry fields are registered: asserted the cycle after selection and held until resolved; entry → ISSUED.
  - An entry that becomes READY in cycle N can be issued (ds_qry high) in cycle N+1 at the earliest.
- ISSUED resolution:
  - If ds_hit while ds_qry is high: blk ← ds_hit_blk, entry → DONE, ds_qry drops next cycle.
  - Else if ds_ack && ds_ack_lq_idx matches: entry → WAIT, ds_qry drops next cycle.
  - Otherwise ds_qry stays high with stable fields.
- WAIT:
  - If ds_ans && ds_ans_lq_idx matches: blk ← ds_ans_blk, entry → DONE.
  - ds_ans addressed to a non-WAIT entry is ignored.
  - Multiple entries may be in WAIT simultaneously.
- Writeback:
  - Registered. wb_valid presents the oldest DONE entry; fields are held while wb_valid && !wb_ready.
  - On wb_ready: entry → WRITTEN, and the next candidate may appear the following cycle.
- Commit:
  - If the head entry is WRITTEN: head → FREE, head++, count--.
  - commit with the head in any other state is ignored.
  - Dispatch and commit in the same cycle leave count unchanged.
- Same-cycle events:
  - ds_ans and ds_hit in the same cycle for different entries both take effect.
  - Full queue with commit: disp_ready is computed from the registered count, so dispatch waits one cycle.
- Reset mid-operation:
  - Asserting reset while ds_qry is high or entries are in WAIT clears everything.
  - Late ds_ack/ds_ans for cleared entries are ignored by the state checks.
  - The same applies after flush.

Decomposition:
- Shared package (fetch package): lq_state_e enum, MEM_IDX_W/BLK_W constants, and the TRUE/FALSE constants already defined there.
- Sub-module `lq_age_picker`: combinational oldest-first selection of an entry matching a state mask, rotated from head. Instantiated twice: once for issue (READY) and once for writeback (DONE).

Test Plan:
1. Reset, then idle 2 cycles → disp_ready=1, ds_qry=0, wb_valid=0, disp_idx=0.
2. Dispatch 1 entry (idx 0), then addr_mem_idx=2 → ds_qry=1, qry_mem_idx=2, qry_lq_idx=0. Then ds_hit with blk 64'hdeadbeefcc00ffee → ds_qry=0 next cycle; wb_valid=1, wb_blk=64'hdeadbeefcc00ffee. Then wb_ready, then commit → count returns to 0.
3. Miss path:
   - Entry idx 1 queried; ds_ack after 2 stall cycles with ds_ack_lq_idx=1 → ds_qry drops, entry in WAIT.
   - Issue a second READY entry meanwhile.
   - ds_ans with lq_idx=1, blk 64'h1234 → wb of idx 1 with 64'h1234.
4. Out-of-order fill:
   - Entries 0 and 1 both miss; ds_ans for 1 arrives before 0.
   - Writeback of 1 occurs first, but commit is blocked until 0 is WRITTEN.
   - Head advances by 2 after two commits.
5. Fill to SIZE=8 → disp_ready=0. Commit the head → disp_ready=1 next cycle. Tail wraps; the next disp_idx equals the old head.
6. Flush while ds_qry=1 and one entry is in WAIT → all outputs back to reset values next cycle. A later ds_ans for the stale index → no wb_valid.

Source files
------------

// File: rtl/load_queue_pkg.sv
// Shared types and constants for the load queue.
//   lq_state_e   : per-entry lifecycle state
//   LQ_MEM_IDX_W : default memory block index width
//   LQ_BLK_W     : default data block width
//   TRUE/FALSE   : single-bit constants
package load_queue_pkg;

    localparam int   LQ_MEM_IDX_W = 16;
    localparam int   LQ_BLK_W     = 64;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        LQ_FREE    = 3'd0,
        LQ_ALLOC   = 3'd1,
        LQ_READY   = 3'd2,
        LQ_ISSUED  = 3'd3,
        LQ_WAIT    = 3'd4,
        LQ_DONE    = 3'd5,
        LQ_WRITTEN = 3'd6
    } lq_state_e;

endpackage

// File: rtl/lq_age_picker.sv
// Oldest-first selector over a circular queue.
// Scans entries starting at the head and returns the first one whose mask
// bit is set.
//   i_mask  : per-entry candidate bits
//   i_head  : oldest entry index
//   o_valid : some entry matched
//   o_idx   : index of the oldest match (head when none)
module lq_age_picker
    import load_queue_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]  i_mask,
    input  logic [IDX_W-1:0] i_head,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_pos;

    // Walk from youngest to oldest so the last hit written is the oldest.
    always_comb begin
        o_valid = FALSE;
        o_idx   = i_head;
        w_pos   = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            w_pos = i_head + IDX_W'(k);
            if (i_mask[w_pos]) begin
                o_valid = TRUE;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/load_queue.sv
// Circular load queue in front of the data-cache stage (ds).
// Allocates at dispatch, captures block indices from address generation,
// issues one query at a time to ds, tracks hit / miss-ack / fill, writes
// loaded blocks back and retires in order on commit. Flush empties it.
//   clock, reset, flush        : clocking, async reset, sync flush
//   disp_valid/ready/idx       : allocation handshake (idx = tail)
//   addr_valid/lq_idx/mem_idx  : block index write for an ALLOC entry
//   ds_qry*                    : registered query to ds
//   ds_hit*, ds_ack*, ds_ans*  : ds responses
//   wb_valid/lq_idx/blk/ready  : registered writeback handshake
//   commit                     : retire head when WRITTEN
module load_queue
    import load_queue_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int IDX_W     = $clog2(SIZE),
    parameter int MEM_IDX_W = LQ_MEM_IDX_W,
    parameter int BLK_W     = LQ_BLK_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    output logic [IDX_W-1:0]     disp_idx,
    input  logic                 addr_valid,
    input  logic [IDX_W-1:0]     addr_lq_idx,
    input  logic [MEM_IDX_W-1:0] addr_mem_idx,
    output logic                 ds_qry,
    output logic [MEM_IDX_W-1:0] ds_qry_mem_idx,
    output logic [IDX_W-1:0]     ds_qry_lq_idx,
    input  logic                 ds_hit,
    input  logic [BLK_W-1:0]     ds_hit_blk,
    input  logic                 ds_ack,
    input  logic [IDX_W-1:0]     ds_ack_lq_idx,
    input  logic                 ds_ans,
    input  logic [IDX_W-1:0]     ds_ans_lq_idx,
    input  logic [BLK_W-1:0]     ds_ans_blk,
    output logic                 wb_valid,
    output logic [IDX_W-1:0]     wb_lq_idx,
    output logic [BLK_W-1:0]     wb_blk,
    input  logic                 wb_ready,
    input  logic                 commit
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(SIZE);

    // Entry storage
    lq_state_e            r_state [SIZE];
    logic [MEM_IDX_W-1:0] r_mem   [SIZE];
    logic [BLK_W-1:0]     r_blk   [SIZE];

    // Pointers
    logic [IDX_W-1:0]     r_head;
    logic [IDX_W-1:0]     r_tail;
    logic [IDX_W:0]       r_count;

    // Query and writeback output registers
    logic                 r_qry;
    logic [IDX_W-1:0]     r_qry_idx;
    logic [MEM_IDX_W-1:0] r_qry_mem;
    logic                 r_wb_valid;
    logic [IDX_W-1:0]     r_wb_idx;
    logic [BLK_W-1:0]     r_wb_blk;

    // Event decode
    logic                 w_disp_fire;
    logic                 w_commit_fire;
    logic                 w_addr_ok;
    logic                 w_issue;
    logic                 w_hit_res;
    logic                 w_ack_res;
    logic                 w_ans_ok;
    logic                 w_wb_take;
    logic                 w_wb_load;

    logic [SIZE-1:0]      w_rdy_mask;
    logic [SIZE-1:0]      w_done_mask;
    logic                 w_iss_vld;
    logic [IDX_W-1:0]     w_iss_idx;
    logic                 w_wb_vld;
    logic [IDX_W-1:0]     w_wb_idx;

    assign disp_ready    = (r_count != FULL_CNT);
    assign disp_idx      = r_tail;
    assign w_disp_fire   = disp_valid && disp_ready;
    assign w_commit_fire = commit && (r_state[r_head] == LQ_WRITTEN);
    assign w_addr_ok     = addr_valid && (r_state[addr_lq_idx] == LQ_ALLOC);

    // r_qry high means exactly one entry is ISSUED, so it gates new issue.
    assign w_issue       = !r_qry && w_iss_vld;
    assign w_hit_res     = r_qry && ds_hit;
    assign w_ack_res     = r_qry && !ds_hit && ds_ack && (ds_ack_lq_idx == r_qry_idx);
    assign w_ans_ok      = ds_ans && (r_state[ds_ans_lq_idx] == LQ_WAIT);

    assign w_wb_take     = r_wb_valid && wb_ready;
    assign w_wb_load     = !r_wb_valid || wb_ready;

    // The entry currently on the writeback port is still DONE; mask it out
    // so the next candidate can be loaded on the same edge it is consumed.
    always_comb begin
        w_rdy_mask  = '0;
        w_done_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_rdy_mask[i]  = (r_state[i] == LQ_READY);
            w_done_mask[i] = (r_state[i] == LQ_DONE) &&
                             !(r_wb_valid && (r_wb_idx == IDX_W'(i)));
        end
    end

    lq_age_picker #(.SIZE(SIZE), .IDX_W(IDX_W)) u_issue_pick (
        .i_mask  (w_rdy_mask),
        .i_head  (r_head),
        .o_valid (w_iss_vld),
        .o_idx   (w_iss_idx)
    );

    lq_age_picker #(.SIZE(SIZE), .IDX_W(IDX_W)) u_wb_pick (
        .i_mask  (w_done_mask),
        .i_head  (r_head),
        .o_valid (w_wb_vld),
        .o_idx   (w_wb_idx)
    );

    // Entry state. Every transition is qualified by the current state, so at
    // most one can apply to a given entry in a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) r_state[i] <= LQ_FREE;
        end else if (flush) begin
            for (int i = 0; i < SIZE; i++) r_state[i] <= LQ_FREE;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (w_disp_fire && (r_tail == IDX_W'(i)))
                    r_state[i] <= LQ_ALLOC;
                if (w_addr_ok && (addr_lq_idx == IDX_W'(i)))
                    r_state[i] <= LQ_READY;
                if (w_issue && (w_iss_idx == IDX_W'(i)))
                    r_state[i] <= LQ_ISSUED;
                if (w_hit_res && (r_qry_idx == IDX_W'(i)))
                    r_state[i] <= LQ_DONE;
                if (w_ack_res && (r_qry_idx == IDX_W'(i)))
                    r_state[i] <= LQ_WAIT;
                if (w_ans_ok && (ds_ans_lq_idx == IDX_W'(i)))
                    r_state[i] <= LQ_DONE;
                if (w_wb_take && (r_wb_idx == IDX_W'(i)))
                    r_state[i] <= LQ_WRITTEN;
                if (w_commit_fire && (r_head == IDX_W'(i)))
                    r_state[i] <= LQ_FREE;
            end
        end
    end

    // Payload needs no reset: it is only read once the state says it is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < SIZE; i++) begin
            if (w_addr_ok && (addr_lq_idx == IDX_W'(i)))
                r_mem[i] <= addr_mem_idx;
            if (w_hit_res && (r_qry_idx == IDX_W'(i)))
                r_blk[i] <= ds_hit_blk;
            else if (w_ans_ok && (ds_ans_lq_idx == IDX_W'(i)))
                r_blk[i] <= ds_ans_blk;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_disp_fire)   r_tail <= r_tail + 1'b1;
            if (w_commit_fire) r_head <= r_head + 1'b1;
            case ({w_disp_fire, w_commit_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Query register: fields stay stable until the entry resolves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_qry     <= FALSE;
            r_qry_idx <= '0;
            r_qry_mem <= '0;
        end else if (flush) begin
            r_qry     <= FALSE;
            r_qry_idx <= '0;
            r_qry_mem <= '0;
        end else if (w_issue) begin
            r_qry     <= TRUE;
            r_qry_idx <= w_iss_idx;
            r_qry_mem <= r_mem[w_iss_idx];
        end else if (w_hit_res || w_ack_res) begin
            r_qry     <= FALSE;
        end
    end

    // Writeback register: held while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_valid <= FALSE;
            r_wb_idx   <= '0;
            r_wb_blk   <= '0;
        end else if (flush) begin
            r_wb_valid <= FALSE;
            r_wb_idx   <= '0;
            r_wb_blk   <= '0;
        end else if (w_wb_load) begin
            r_wb_valid <= w_wb_vld;
            if (w_wb_vld) begin
                r_wb_idx <= w_wb_idx;
                r_wb_blk <= r_blk[w_wb_idx];
            end
        end
    end

    assign ds_qry         = r_qry;
    assign ds_qry_lq_idx  = r_qry_idx;
    assign ds_qry_mem_idx = r_qry_mem;
    assign wb_valid       = r_wb_valid;
    assign wb_lq_idx      = r_wb_idx;
    assign wb_blk         = r_wb_blk;

endmodule

// File: tb/tb_load_queue.sv
module tb_load_queue;

    localparam int SIZE = 8;
    localparam int IW   = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          disp_valid;
    logic          disp_ready;
    logic [IW-1:0] disp_idx;
    logic          addr_valid;
    logic [IW-1:0] addr_lq_idx;
    logic [15:0]   addr_mem_idx;
    logic          ds_qry;
    logic [15:0]   ds_qry_mem_idx;
    logic [IW-1:0] ds_qry_lq_idx;
    logic          ds_hit;
    logic [63:0]   ds_hit_blk;
    logic          ds_ack;
    logic [IW-1:0] ds_ack_lq_idx;
    logic          ds_ans;
    logic [IW-1:0] ds_ans_lq_idx;
    logic [63:0]   ds_ans_blk;
    logic          wb_valid;
    logic [IW-1:0] wb_lq_idx;
    logic [63:0]   wb_blk;
    logic          wb_ready;
    logic          commit;

    int n_chk = 0;
    int n_err = 0;

    load_queue #(.SIZE(SIZE)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_idx       (disp_idx),
        .addr_valid     (addr_valid),
        .addr_lq_idx    (addr_lq_idx),
        .addr_mem_idx   (addr_mem_idx),
        .ds_qry         (ds_qry),
        .ds_qry_mem_idx (ds_qry_mem_idx),
        .ds_qry_lq_idx  (ds_qry_lq_idx),
        .ds_hit         (ds_hit),
        .ds_hit_blk     (ds_hit_blk),
        .ds_ack         (ds_ack),
        .ds_ack_lq_idx  (ds_ack_lq_idx),
        .ds_ans         (ds_ans),
        .ds_ans_lq_idx  (ds_ans_lq_idx),
        .ds_ans_blk     (ds_ans_blk),
        .wb_valid       (wb_valid),
        .wb_lq_idx      (wb_lq_idx),
        .wb_blk         (wb_blk),
        .wb_ready       (wb_ready),
        .commit         (commit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic addr_wr(input logic [IW-1:0] idx, input logic [15:0] mem);
        addr_valid   = 1'b1;
        addr_lq_idx  = idx;
        addr_mem_idx = mem;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        addr_valid = 1'b0; addr_lq_idx = '0; addr_mem_idx = '0;
        ds_hit = 1'b0; ds_hit_blk = '0; ds_ack = 1'b0; ds_ack_lq_idx = '0;
        ds_ans = 1'b0; ds_ans_lq_idx = '0; ds_ans_blk = '0;
        wb_ready = 1'b0; commit = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // 1: reset state
        tick(); tick();
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_ds_qry", ds_qry, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_disp_idx", disp_idx, 0);
        chk("rst_wb_blk", wb_blk, 0);

        // 2: hit path
        disp_valid = 1'b1; tick(); disp_valid = 1'b0;
        chk("t2_disp_idx", disp_idx, 1);
        addr_wr(0, 16'd2); tick(); addr_valid = 1'b0;
        chk("t2_qry_not_early", ds_qry, 0);
        tick();
        chk("t2_qry", ds_qry, 1);
        chk("t2_qry_mem", ds_qry_mem_idx, 2);
        chk("t2_qry_idx", ds_qry_lq_idx, 0);
        ds_hit = 1'b1; ds_hit_blk = 64'hdeadbeefcc00ffee; tick(); ds_hit = 1'b0;
        chk("t2_qry_drop", ds_qry, 0);
        chk("t2_wb_not_yet", wb_valid, 0);
        tick();
        chk("t2_wb_valid", wb_valid, 1);
        chk("t2_wb_blk", wb_blk, 64'hdeadbeefcc00ffee);
        chk("t2_wb_idx", wb_lq_idx, 0);
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        chk("t2_wb_cons", wb_valid, 0);
        // commit together with a dispatch: count holds at 1
        commit = 1'b1; disp_valid = 1'b1; tick(); commit = 1'b0; disp_valid = 1'b0;
        chk("t2_count", dut.r_count, 1);
        chk("t2_head", dut.r_head, 1);
        chk("t2_tail", disp_idx, 2);

        // 3: miss path with a second issue while entry 1 waits
        disp_valid = 1'b1; tick(); disp_valid = 1'b0;
        addr_wr(1, 16'h11); tick();
        addr_wr(2, 16'h22); tick(); addr_valid = 1'b0;
        chk("t3_qry", ds_qry, 1);
        chk("t3_qry_idx", ds_qry_lq_idx, 1);
        chk("t3_qry_mem", ds_qry_mem_idx, 16'h11);
        ds_ack = 1'b1; ds_ack_lq_idx = 2; tick(); ds_ack = 1'b0;
        chk("t3_bad_ack_qry", ds_qry, 1);
        chk("t3_bad_ack_idx", ds_qry_lq_idx, 1);
        tick();
        ds_ack = 1'b1; ds_ack_lq_idx = 1; tick(); ds_ack = 1'b0;
        chk("t3_ack_drop", ds_qry, 0);
        tick();
        chk("t3_qry2", ds_qry, 1);
        chk("t3_qry2_idx", ds_qry_lq_idx, 2);
        chk("t3_qry2_mem", ds_qry_mem_idx, 16'h22);
        ds_ans = 1'b1; ds_ans_lq_idx = 1; ds_ans_blk = 64'h1234;
        ds_hit = 1'b1; ds_hit_blk = 64'h5555;
        tick(); ds_ans = 1'b0; ds_hit = 1'b0;
        chk("t3_qry2_drop", ds_qry, 0);
        tick();
        chk("t3_wb1_valid", wb_valid, 1);
        chk("t3_wb1_idx", wb_lq_idx, 1);
        chk("t3_wb1_blk", wb_blk, 64'h1234);
        tick();
        chk("t3_wb1_hold", wb_lq_idx, 1);
        wb_ready = 1'b1; tick();
        chk("t3_wb2_valid", wb_valid, 1);
        chk("t3_wb2_idx", wb_lq_idx, 2);
        chk("t3_wb2_blk", wb_blk, 64'h5555);
        tick(); wb_ready = 1'b0;
        chk("t3_wb_empty", wb_valid, 0);
        commit = 1'b1; tick(); tick(); commit = 1'b0;
        chk("t3_count", dut.r_count, 0);
        chk("t3_tail", disp_idx, 3);

        // 4: out-of-order fill, in-order commit
        disp_valid = 1'b1; tick(); tick(); disp_valid = 1'b0;
        addr_wr(3, 16'h30); tick();
        addr_wr(4, 16'h40); tick(); addr_valid = 1'b0;
        chk("t4_qry3", ds_qry_lq_idx, 3);
        ds_ack = 1'b1; ds_ack_lq_idx = 3; tick(); ds_ack = 1'b0;
        tick();
        chk("t4_qry4", ds_qry_lq_idx, 4);
        chk("t4_qry4_v", ds_qry, 1);
        ds_ack = 1'b1; ds_ack_lq_idx = 4; tick(); ds_ack = 1'b0;
        ds_ans = 1'b1; ds_ans_lq_idx = 4; ds_ans_blk = 64'h4444; tick(); ds_ans = 1'b0;
        tick();
        chk("t4_wb4_idx", wb_lq_idx, 4);
        chk("t4_wb4_blk", wb_blk, 64'h4444);
        wb_ready = 1'b1; commit = 1'b1; tick(); wb_ready = 1'b0; commit = 1'b0;
        chk("t4_commit_blocked", dut.r_count, 2);
        ds_ans = 1'b1; ds_ans_lq_idx = 4; ds_ans_blk = 64'hbad; tick(); ds_ans = 1'b0;
        tick();
        chk("t4_stray_ans", wb_valid, 0);
        ds_ans = 1'b1; ds_ans_lq_idx = 3; ds_ans_blk = 64'h3333; tick(); ds_ans = 1'b0;
        tick();
        chk("t4_wb3_idx", wb_lq_idx, 3);
        chk("t4_wb3_blk", wb_blk, 64'h3333);
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        commit = 1'b1; tick(); tick(); commit = 1'b0;
        chk("t4_head", dut.r_head, 5);
        chk("t4_count", dut.r_count, 0);

        // 5: full queue, commit then wrap
        disp_valid = 1'b1;
        for (int i = 0; i < SIZE; i++) tick();
        chk("t5_full", disp_ready, 0);
        tick(); disp_valid = 1'b0;
        chk("t5_full_count", dut.r_count, 8);
        chk("t5_full_tail", disp_idx, 5);
        addr_wr(5, 16'h50); tick(); addr_valid = 1'b0;
        tick();
        chk("t5_qry", ds_qry_lq_idx, 5);
        ds_hit = 1'b1; ds_hit_blk = 64'h5050; tick(); ds_hit = 1'b0;
        tick();
        chk("t5_wb_blk", wb_blk, 64'h5050);
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        commit = 1'b1; disp_valid = 1'b1; tick(); commit = 1'b0;
        chk("t5_count", dut.r_count, 7);
        chk("t5_ready", disp_ready, 1);
        chk("t5_wrap_idx", disp_idx, 5);
        tick(); disp_valid = 1'b0;
        chk("t5_refull", disp_ready, 0);
        chk("t5_tail", disp_idx, 6);

        // 6: flush with a live query and a waiting entry
        addr_wr(6, 16'h60); tick();
        addr_wr(7, 16'h70); tick(); addr_valid = 1'b0;
        ds_ack = 1'b1; ds_ack_lq_idx = 6; tick(); ds_ack = 1'b0;
        tick();
        chk("t6_qry7", ds_qry_lq_idx, 7);
        chk("t6_qry7_mem", ds_qry_mem_idx, 16'h70);
        flush = 1'b1; disp_valid = 1'b1; tick(); flush = 1'b0; disp_valid = 1'b0;
        chk("t6_qry", ds_qry, 0);
        chk("t6_qry_idx", ds_qry_lq_idx, 0);
        chk("t6_qry_mem", ds_qry_mem_idx, 0);
        chk("t6_wb", wb_valid, 0);
        chk("t6_ready", disp_ready, 1);
        chk("t6_disp_idx", disp_idx, 0);
        ds_ans = 1'b1; ds_ans_lq_idx = 6; ds_ans_blk = 64'hbeef;
        ds_ack = 1'b1; ds_ack_lq_idx = 7;
        tick(); ds_ans = 1'b0; ds_ack = 1'b0;
        tick();
        chk("t6_stale_wb", wb_valid, 0);
        chk("t6_stale_qry", ds_qry, 0);
        chk("t6_count", dut.r_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
